// File: rtl/dec_conv_arbiter.sv
// Round-robin front end that time-shares one BIN24_to_DEC8 converter between
// N_REQ requesters and returns each BCD result tagged with its owner's id.
module dec_conv_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int CONV_WAIT = 84
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [24*N_REQ-1:0]   req_bin,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  conv_st,
    output logic [23:0]           conv_bin,
    input  logic [31:0]           conv_dec,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_dec,
    output logic [ID_W-1:0]       resp_id,
    output logic                  busy
);

    localparam int CNT_W = $clog2(CONV_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              conv_st_r;
    logic [23:0]       conv_bin_r;
    logic              resp_valid_r;
    logic [31:0]       resp_dec_r;
    logic [ID_W-1:0]   resp_id_r;
    logic              busy_r;

    logic              grant_found_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [ID_W-1:0]   next_ptr_s;
    logic [23:0]       sel_bin_s;
    logic [N_REQ-1:0]  req_ready_s;
    logic [ID_W:0]     sum_s;
    logic [ID_W-1:0]   idx_s;

    // Rotating priority search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        sum_s         = {(ID_W+1){1'b0}};
        idx_s         = {ID_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            if (sum_s >= (ID_W+1)'(N_REQ)) begin
                sum_s = sum_s - (ID_W+1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[ID_W-1:0];
            if (!grant_found_s && req_valid[idx_s]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand mux, wrapped pointer and the one-hot accept offered only in IDLE.
    always_comb begin
        sel_bin_s = 24'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_s == ID_W'(i)) begin
                sel_bin_s = req_bin[24*i +: 24];
            end else begin
                sel_bin_s = sel_bin_s;
            end
        end
        if (grant_id_s == ID_W'(N_REQ-1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = grant_id_s + ID_W'(1);
        end
        if ((state_r == S_IDLE) && grant_found_s) begin
            req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_s;
        end else begin
            req_ready_s = {N_REQ{1'b0}};
        end
    end

    // Sequencer: accept, pulse st, sit out the worst-case conversion, return result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            rr_ptr_r     <= {ID_W{1'b0}};
            wait_cnt_r   <= {CNT_W{1'b0}};
            conv_st_r    <= 1'b0;
            conv_bin_r   <= 24'd0;
            resp_valid_r <= 1'b0;
            resp_dec_r   <= 32'd0;
            resp_id_r    <= {ID_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_found_s) begin
                        conv_bin_r <= sel_bin_s;
                        resp_id_r  <= grant_id_s;
                        rr_ptr_r   <= next_ptr_s;
                        conv_st_r  <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= S_START;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_START: begin
                    conv_st_r  <= 1'b0;
                    wait_cnt_r <= CNT_W'(CONV_WAIT-1);
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    // Converter has no done flag; the count covers its worst case.
                    if (wait_cnt_r == {CNT_W{1'b0}}) begin
                        resp_dec_r   <= conv_dec;
                        resp_valid_r <= 1'b1;
                        state_r      <= S_RESP;
                    end else begin
                        wait_cnt_r   <= wait_cnt_r - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= S_IDLE;
                    end else begin
                        state_r      <= S_RESP;
                    end
                end
                default: begin
                    conv_st_r    <= 1'b0;
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign conv_st    = conv_st_r;
    assign conv_bin   = conv_bin_r;
    assign resp_valid = resp_valid_r;
    assign resp_dec   = resp_dec_r;
    assign resp_id    = resp_id_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_dec_conv_arbiter.sv
// Directed bench for dec_conv_arbiter with a behavioural converter that only
// publishes its result 80 edges after st, so early capture is visible.
module tb_dec_conv_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = 4'd0;
    logic [95:0]  req_bin = 96'd0;
    logic [3:0]   req_ready;
    logic         conv_st;
    logic [23:0]  conv_bin;
    logic [31:0]  conv_dec = 32'd0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [31:0]  resp_dec;
    logic [1:0]   resp_id;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;
    int conv_cnt = 0;
    logic multi_hot = 1'b0;

    dec_conv_arbiter #(.N_REQ(4), .ID_W(2), .CONV_WAIT(84)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin),
        .req_ready(req_ready), .conv_st(conv_st), .conv_bin(conv_bin),
        .conv_dec(conv_dec), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dec(resp_dec), .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bin2bcd(input logic [23:0] b);
        int v;
        logic [31:0] r;
        v = int'(b);
        r = 32'd0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Converter stand-in: output is garbage-free zero until the conversion completes.
    always @(posedge clk) begin
        if (conv_st) begin
            conv_dec <= 32'd0;
            conv_cnt <= 80;
        end else if (conv_cnt != 0) begin
            conv_cnt <= conv_cnt - 1;
            if (conv_cnt == 1) conv_dec <= bin2bcd(conv_bin);
        end
    end

    always @(negedge clk) begin
        if ($countones(req_ready) > 1) multi_hot = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full single job with exact latency checks; DUT must be idle at a negedge.
    task automatic job(input int id, input logic [23:0] bin, input logic [31:0] exp_dec);
        int st_seen;
        logic early;
        req_bin[24*id +: 24] = bin;
        req_valid = 4'b0001 << id;
        resp_ready = 1'b1;
        #1;
        check("job_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << id});
        @(negedge clk);
        check("job_st", {31'd0, conv_st}, 32'd1);
        check("job_bin", {8'd0, conv_bin}, {8'd0, bin});
        req_valid = 4'd0;
        st_seen = 1;
        early = 1'b0;
        for (int k = 0; k < 84; k++) begin
            @(negedge clk);
            st_seen += int'(conv_st);
            if (resp_valid) early = 1'b1;
        end
        check("job_st_once", st_seen, 32'd1);
        check("job_not_early", {31'd0, early}, 32'd0);
        @(negedge clk);
        check("job_valid", {31'd0, resp_valid}, 32'd1);
        check("job_dec", resp_dec, exp_dec);
        check("job_id", {30'd0, resp_id}, id);
        @(negedge clk);
        check("job_done", {30'd0, resp_valid, busy}, 32'd0);
    endtask

    task automatic wait_resp(input string tag, input int exp_id, input logic [31:0] exp_dec);
        int n;
        n = 0;
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_id"}, {30'd0, resp_id}, exp_id);
        check({tag, "_dec"}, resp_dec, exp_dec);
    endtask

    initial begin
        logic [31:0] cap_dec;
        logic [1:0]  cap_id;
        logic        stable;
        logic        seen_valid;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_outs", {resp_dec}, 32'd0);
        check("rst_ctl", {24'd0, req_ready, conv_st, resp_valid, busy, resp_id[0]}, 32'd0);
        check("rst_bin", {6'd0, resp_id, conv_bin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job and boundary operands
        job(2, 24'd1234567, 32'h01234567);
        job(0, 24'd0, 32'h00000000);
        job(3, 24'd16777215, 32'h16777215);

        // All requesters valid: strict rotation from rr_ptr=0
        req_bin = {24'd44, 24'd33, 24'd22, 24'd11};
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        wait_resp("rr0", 0, 32'h11); @(negedge clk);
        wait_resp("rr1", 1, 32'h22); @(negedge clk);
        wait_resp("rr2", 2, 32'h33); @(negedge clk);
        wait_resp("rr3", 3, 32'h44); @(negedge clk);
        wait_resp("rr4", 0, 32'h11);
        req_valid = 4'b1000;
        @(negedge clk);
        check("one_hot", {31'd0, multi_hot}, 32'd0);

        // Lone requester 3, then 0 and 3 together
        wait_resp("lone3", 3, 32'h44);
        req_valid = 4'b1001;
        @(negedge clk);
        wait_resp("wrap0", 0, 32'h11); @(negedge clk);
        wait_resp("then3", 3, 32'h44);
        req_valid = 4'b0000;
        @(negedge clk);

        // Response back-pressure holds RESP
        resp_ready = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        wait_resp("bp", 1, 32'h22);
        cap_dec = resp_dec;
        cap_id = resp_id;
        req_valid = 4'b1111;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!(resp_valid === 1'b1 && resp_dec === cap_dec && resp_id === cap_id
                  && req_ready === 4'd0 && busy === 1'b1)) stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {30'd0, resp_valid, busy}, 32'd0);
        check("bp_idle_ready", {31'd0, req_ready != 4'd0}, 32'd1);
        req_valid = 4'b0000;
        @(negedge clk);

        // Reset asserted in the middle of WAIT
        req_bin[48 +: 24] = 24'd4321;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {28'd0, conv_st, resp_valid, busy, 1'b0}, 32'd0);
        check("mid_rst_data", {6'd0, resp_id, conv_bin}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (resp_valid || busy) seen_valid = 1'b1;
        end
        check("mid_rst_discard", {31'd0, seen_valid}, 32'd0);
        job(0, 24'd999999, 32'h00999999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
